muldiv_ctrl: RTL and testbench

Sequencing controller between the multicycle main control FSM and the HI/LO multiply/divide unit. It accepts one HI/LO-class instruction at a time over a req/ack handshake. Multiply and divide are issued fire-and-forget, so the processor keeps running until it next touches HI/LO. The controller stalls mfhi/mflo/mthi/mtlo and back-to-back mult/div until the unit is idle, traps divide-by-zero before issue, and owns the unit's synchronous reset.

---
 rtl/muldiv_ctrl_pkg.sv | 44 ++++
 rtl/muldiv_ctrl.sv | 167 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencing controller:
// MDC op codes, controller state encoding and MDC-to-unit op translation.
package muldiv_ctrl_pkg;

   // Requests arriving from the main control FSM
   localparam logic [2:0] MDC_MULT  = 3'd0;
   localparam logic [2:0] MDC_MULTU = 3'd1;
   localparam logic [2:0] MDC_DIV   = 3'd2;
   localparam logic [2:0] MDC_DIVU  = 3'd3;
   localparam logic [2:0] MDC_MFHI  = 3'd4;
   localparam logic [2:0] MDC_MFLO  = 3'd5;
   localparam logic [2:0] MDC_MTHI  = 3'd6;
   localparam logic [2:0] MDC_MTLO  = 3'd7;

   // Op codes understood by the multiply/divide unit
   localparam logic [2:0] MDNONE = 3'd0;
   localparam logic [2:0] MDMUL  = 3'd1;
   localparam logic [2:0] MDDIV  = 3'd2;
   localparam logic [2:0] MDMULU = 3'd3;
   localparam logic [2:0] MDDIVU = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_RUN   = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4,
      S_DZ    = 3'd5
   } mdc_state_e;

   function automatic logic [2:0] mdc_to_md(input logic [2:0] op);
      logic [2:0] r;
      r = MDNONE;
      unique case (op)
         MDC_MULT:  r = MDMUL;
         MDC_MULTU: r = MDMULU;
         MDC_DIV:   r = MDDIV;
         MDC_DIVU:  r = MDDIVU;
         default:   r = MDNONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencing controller. One request at a time over
// req_i/ack_o; mult/div are fire-and-forget, later HI/LO accesses stall in
// RUN until the unit is idle. Div-by-zero is trapped before issue.
// Ports: MDC_clk/MDC_reset_n clock and async active-low reset;
//   req_i/op_i/a_i/b_i request, ack_o/rdata_o/dz_o response, err_o sticky
//   timeout; md_* outputs drive the unit, md_busy_i/md_hlrd_i come back.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic        MDC_clk,
   input  logic        MDC_reset_n,
   input  logic        req_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        dz_o,
   output logic        err_o,
   output logic [31:0] md_a_o,
   output logic [31:0] md_b_o,
   output logic [2:0]  md_op_o,
   output logic        md_start_o,
   output logic        md_hlwe_o,
   output logic        md_hlsrc_o,
   output logic        md_reset_o,
   input  logic        md_busy_i,
   input  logic [31:0] md_hlrd_i
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mdc_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_outst, w_outst_nxt;
   logic              r_err, w_err_nxt;
   logic [31:0]       r_md_a, w_md_a_nxt;
   logic [31:0]       r_md_b, w_md_b_nxt;
   logic [2:0]        r_md_op, w_md_op_nxt;
   logic              r_hlsrc, w_hlsrc_nxt;
   logic              r_tmo, w_tmo_nxt;
   logic              r_rel;

   logic w_is_mul;
   logic w_is_div;
   logic w_is_rd;
   logic w_b_zero;
   logic w_sel_hi;
   logic w_run_done;

   assign w_is_mul = (op_i == MDC_MULT) || (op_i == MDC_MULTU);
   assign w_is_div = (op_i == MDC_DIV) || (op_i == MDC_DIVU);
   assign w_is_rd  = (op_i == MDC_MFHI) || (op_i == MDC_MFLO);
   assign w_b_zero = (b_i == 32'd0);
   assign w_sel_hi = (op_i == MDC_MFHI) || (op_i == MDC_MTHI);

   // Busy is only rising on the edge after start, so the first RUN
   // cycle cannot be trusted to show it.
   assign w_run_done = (r_cnt != '0) && !md_busy_i;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_outst_nxt = r_outst;
      w_err_nxt   = r_err;
      w_md_a_nxt  = r_md_a;
      w_md_b_nxt  = r_md_b;
      w_md_op_nxt = r_md_op;
      w_hlsrc_nxt = 1'b0;
      w_tmo_nxt   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (req_i) begin
               unique case (1'b1)
                  w_is_mul, w_is_div && !w_b_zero: begin
                     w_md_a_nxt  = a_i;
                     w_md_b_nxt  = b_i;
                     w_md_op_nxt = mdc_to_md(op_i);
                     w_state_nxt = S_ISSUE;
                  end
                  w_is_div && w_b_zero: begin
                     w_state_nxt = S_DZ;
                  end
                  w_is_rd: begin
                     w_hlsrc_nxt = w_sel_hi;
                     w_state_nxt = S_READ;
                  end
                  default: begin
                     w_md_a_nxt  = a_i;
                     w_hlsrc_nxt = w_sel_hi;
                     w_state_nxt = S_WRITE;
                  end
               endcase
            end
         end
         S_ISSUE: begin
            w_cnt_nxt   = '0;
            w_outst_nxt = 1'b1;
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (w_run_done) begin
               w_outst_nxt = 1'b0;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_err_nxt   = 1'b1;
               w_tmo_nxt   = 1'b1;
               w_outst_nxt = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         S_READ, S_WRITE, S_DZ: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge MDC_clk or negedge MDC_reset_n) begin
      if (!MDC_reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_outst <= 1'b0;
         r_err   <= 1'b0;
         r_md_a  <= 32'd0;
         r_md_b  <= 32'd0;
         r_md_op <= MDNONE;
         r_hlsrc <= 1'b0;
         r_tmo   <= 1'b0;
         r_rel   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_outst <= w_outst_nxt;
         r_err   <= w_err_nxt;
         r_md_a  <= w_md_a_nxt;
         r_md_b  <= w_md_b_nxt;
         r_md_op <= w_md_op_nxt;
         r_hlsrc <= w_hlsrc_nxt;
         r_tmo   <= w_tmo_nxt;
         r_rel   <= 1'b1;
      end
   end

   assign ack_o      = (r_state == S_ISSUE) || (r_state == S_READ) ||
                       (r_state == S_WRITE) || (r_state == S_DZ);
   assign dz_o       = (r_state == S_DZ);
   assign md_start_o = (r_state == S_ISSUE);
   // A HI/LO write during an op would freeze the unit's sequencer.
   assign md_hlwe_o  = (r_state == S_WRITE) && !r_outst;
   assign md_hlsrc_o = r_hlsrc;
   assign rdata_o    = (r_state == S_READ) ? md_hlrd_i : 32'd0;
   assign err_o      = r_err;
   assign md_a_o     = r_md_a;
   assign md_b_o     = r_md_b;
   assign md_op_o    = r_md_op;
   // Unit reset covers the first edge after release and a timeout abort.
   assign md_reset_o = !r_rel || r_tmo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with a behavioural multiply/divide
// unit stub and a transaction-level HI/LO reference model.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_i;
   logic [2:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        ack_o, dz_o, err_o;
   logic [31:0] rdata_o, md_a_o, md_b_o, md_hlrd_i;
   logic [2:0]  md_op_o;
   logic        md_start_o, md_hlwe_o, md_hlsrc_o, md_reset_o, md_busy_i;

   muldiv_ctrl #(.TIMEOUT(TMO), .CNT_W(6)) dut (
      .MDC_clk(clk), .MDC_reset_n(rst_n),
      .req_i(req_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .ack_o(ack_o), .rdata_o(rdata_o), .dz_o(dz_o), .err_o(err_o),
      .md_a_o(md_a_o), .md_b_o(md_b_o), .md_op_o(md_op_o),
      .md_start_o(md_start_o), .md_hlwe_o(md_hlwe_o),
      .md_hlsrc_o(md_hlsrc_o), .md_reset_o(md_reset_o),
      .md_busy_i(md_busy_i), .md_hlrd_i(md_hlrd_i)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int hlwe_viol = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [63:0] calc(input int kind,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
      logic signed [63:0] sa, sb2;
      logic signed [31:0] x, y;
      sa = {{32{a[31]}}, a};
      sb2 = {{32{b[31]}}, b};
      x = a;
      y = b;
      case (kind)
         0: return sa * sb2;
         1: return {32'd0, a} * {32'd0, b};
         2: return {x % y, x / y};
         3: return {a % b, a / b};
         default: return 64'hBAD0BAD0BAD0BAD0;
      endcase
   endfunction

   // ---------------- unit stub ----------------
   logic        u_busy = 1'b1;
   logic [31:0] u_hi = 32'd0, u_lo = 32'd0, u_a, u_b;
   logic [2:0]  u_op;
   int          u_rem = 0;
   int          lat = 4;
   logic        force_busy = 1'b0;

   assign md_busy_i = u_busy | force_busy;
   assign md_hlrd_i = md_hlsrc_o ? u_hi : u_lo;

   function automatic int md_kind(input logic [2:0] op);
      case (op)
         MDMUL:   return 0;
         MDMULU:  return 1;
         MDDIV:   return 2;
         MDDIVU:  return 3;
         default: return 9;
      endcase
   endfunction

   always @(posedge clk) begin
      if (md_reset_o) begin
         u_hi <= 32'd0;
         u_lo <= 32'd0;
         u_rem <= 0;
      end else if (md_start_o) begin
         u_busy <= 1'b1;
         u_rem <= lat;
         u_op <= md_op_o;
         u_a <= md_a_o;
         u_b <= md_b_o;
      end else begin
         if (md_hlwe_o) begin
            if (md_hlsrc_o) u_hi <= md_a_o;
            else u_lo <= md_a_o;
         end
         if (u_rem != 0) begin
            u_rem <= u_rem - 1;
            if (u_rem == 1) begin
               {u_hi, u_lo} <= calc(md_kind(u_op), u_a, u_b);
               u_busy <= 1'b0;
            end
         end
      end
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      logic        start;
      logic        dz;
      logic        rd;
      logic        wr;
      logic        hlsrc;
      logic [31:0] data;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  mdop;
   } exp_t;

   exp_t sbq[$];
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

   function automatic logic [2:0] xl(input logic [2:0] op);
      case (op)
         MDC_MULT:  return MDMUL;
         MDC_MULTU: return MDMULU;
         MDC_DIV:   return MDDIV;
         default:   return MDDIVU;
      endcase
   endfunction

   function automatic logic is_issue(input logic [2:0] op,
                                     input logic [31:0] b);
      return (op <= 3'd1) || ((op <= 3'd3) && (b != 32'd0));
   endfunction

   task automatic push_exp(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      exp_t e;
      logic [63:0] r;
      e = '{default: '0};
      if (op <= 3'd3) begin
         if (!is_issue(op, b)) begin
            e.dz = 1'b1;
         end else begin
            e.start = 1'b1;
            e.mdop = xl(op);
            e.a = a;
            e.b = b;
            r = calc(int'(op), a, b);
            m_hi = r[63:32];
            m_lo = r[31:0];
         end
      end else if (op == MDC_MFHI || op == MDC_MFLO) begin
         e.rd = 1'b1;
         e.hlsrc = (op == MDC_MFHI);
         e.data = (op == MDC_MFHI) ? m_hi : m_lo;
      end else begin
         e.wr = 1'b1;
         e.hlsrc = (op == MDC_MTHI);
         e.a = a;
         if (op == MDC_MTHI) m_hi = a;
         else m_lo = a;
      end
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && (ack_o || md_start_o || dz_o)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_ack", 32'(ack_o), 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("ack", 32'(ack_o), 32'd1);
            chk("start", 32'(md_start_o), 32'(e.start));
            chk("dz", 32'(dz_o), 32'(e.dz));
            chk("hlwe", 32'(md_hlwe_o), 32'(e.wr));
            if (e.start) begin
               chk("md_op", 32'(md_op_o), 32'(e.mdop));
               chk("md_a", md_a_o, e.a);
               chk("md_b", md_b_o, e.b);
            end
            if (e.rd) begin
               chk("rdata", rdata_o, e.data);
               chk("rd_hlsrc", 32'(md_hlsrc_o), 32'(e.hlsrc));
            end
            if (e.wr) begin
               chk("wr_a", md_a_o, e.a);
               chk("wr_hlsrc", 32'(md_hlsrc_o), 32'(e.hlsrc));
            end
         end
      end
   end

   // Issue one request at posedge+1 and wait for its ack; n counts the
   // negedges seen, so an immediate one-cycle ack gives n == 2.
   task automatic do_req(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int n);
      push_exp(op, a, b);
      req_i = 1'b1;
      op_i = op;
      a_i = a;
      b_i = b;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (md_hlwe_o && md_busy_i) hlwe_viol++;
      end while (!ack_o && n < 200);
      if (!ack_o) chk("ack_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int n, k, g, exp_n, prev_lat;
      logic prev_iss;
      logic [2:0] op;
      logic [31:0] a, b;

      rst_n = 1'b0;
      req_i = 1'b0;
      op_i = 3'd0;
      a_i = 32'd0;
      b_i = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack_o), 32'd0);
      chk("rst_dz", 32'(dz_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_start", 32'(md_start_o), 32'd0);
      chk("rst_hlwe", 32'(md_hlwe_o), 32'd0);
      chk("rst_hlsrc", 32'(md_hlsrc_o), 32'd0);
      chk("rst_mdrst", 32'(md_reset_o), 32'd1);
      chk("rst_md_a", md_a_o, 32'd0);
      chk("rst_md_b", md_b_o, 32'd0);
      chk("rst_md_op", 32'(md_op_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_mdrst_hold", 32'(md_reset_o), 32'd1);
      @(posedge clk);
      #1;
      chk("rel_mdrst_drop", 32'(md_reset_o), 32'd0);

      // mult then stalled mflo, then mfhi
      lat = 6;
      do_req(MDC_MULT, 32'd7, 32'hFFFFFFFD, n);
      chk("mult_lat", n, 2);
      do_req(MDC_MFLO, 32'd0, 32'd0, n);
      chk("mflo_stall", n, lat + 3);
      do_req(MDC_MFHI, 32'd0, 32'd0, n);
      chk("mfhi_lat", n, 2);

      // signed and unsigned divide
      lat = 10;
      do_req(MDC_DIV, 32'hFFFFFFF9, 32'd2, n);
      chk("div_lat", n, 2);
      do_req(MDC_MFLO, 32'd0, 32'd0, n);
      chk("div_mflo_stall", n, lat + 3);
      do_req(MDC_MFHI, 32'd0, 32'd0, n);
      lat = 3;
      do_req(MDC_DIVU, 32'hFFFFFFF9, 32'd2, n);
      do_req(MDC_MFLO, 32'd0, 32'd0, n);
      do_req(MDC_MFHI, 32'd0, 32'd0, n);

      // divide by zero
      do_req(MDC_DIV, 32'd5, 32'd0, n);
      chk("dz_lat", n, 2);
      do_req(MDC_MFHI, 32'd0, 32'd0, n);

      // mthi while a mult is running
      lat = 8;
      hlwe_viol = 0;
      do_req(MDC_MULT, 32'h00010001, 32'h00020003, n);
      do_req(MDC_MTHI, 32'h12345678, 32'd0, n);
      chk("mthi_stall", n, lat + 3);
      chk("hlwe_while_busy", hlwe_viol, 0);
      do_req(MDC_MFHI, 32'd0, 32'd0, n);

      // timeout with busy stuck high
      force_busy = 1'b1;
      lat = 3;
      do_req(MDC_MULT, 32'd3, 32'd5, n);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!err_o && k < 200);
      chk("tmo_cycles", k, TMO + 1);
      chk("tmo_mdrst_on", 32'(md_reset_o), 32'd1);
      @(negedge clk);
      chk("tmo_mdrst_off", 32'(md_reset_o), 32'd0);
      chk("err_sticky", 32'(err_o), 32'd1);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(posedge clk);
      #1;
      do_req(MDC_MFLO, 32'd0, 32'd0, n);
      chk("tmo_mflo_lat", n, 2);
      force_busy = 1'b0;

      // reset in the middle of a divide
      lat = 20;
      do_req(MDC_DIV, 32'd100, 32'd7, n);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(ack_o), 32'd0);
      chk("mid_rst_mdrst", 32'(md_reset_o), 32'd1);
      chk("mid_rst_err", 32'(err_o), 32'd0);
      chk("mid_rst_sb", sbq.size(), 0);
      sbq.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel2_mdrst_hold", 32'(md_reset_o), 32'd1);
      @(posedge clk);
      #1;
      chk("rel2_mdrst_drop", 32'(md_reset_o), 32'd0);
      do_req(MDC_MFHI, 32'd0, 32'd0, n);
      chk("stale_busy_mfhi_lat", n, 2);

      // randomized traffic
      prev_iss = 1'b0;
      prev_lat = 0;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         if (op == MDC_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF)
            b = 32'd1;
         g = $urandom_range(0, 3);
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         exp_n = 2;
         if (prev_iss && (prev_lat + 3 - g) > 2) exp_n = prev_lat + 3 - g;
         lat = $urandom_range(1, 12);
         do_req(op, a, b, n);
         chk("rand_lat", n, exp_n);
         prev_iss = is_issue(op, b);
         prev_lat = lat;
      end
      repeat (20) @(posedge clk);
      chk("sb_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
